// File: rtl/plab5_mcore_mem_resp_cmsg_unpack_queue.sv
// -----------------------------------------------------------------------------
// plab5_mcore_mem_resp_cmsg_unpack_queue
//
// A two-entry FIFO for packed memory-response control messages. Each entry
// holds the packed message and the security domain it arrived with. The
// head entry is unpacked combinationally into its type, opaque and len fields.
//
// There is no bypass path. A message enqueued in cycle N first appears at the
// dequeue side in cycle N+1. enq_rdy depends only on the queue's occupancy and
// on reset. It never depends on deq_rdy, so a full queue refuses a new entry
// even in a cycle where the head is being dequeued.
//
// Ports
//   clk         in   clock; all state updates on the rising edge
//   reset       in   synchronous active-high reset
//   enq_val     in   packed message valid
//   enq_rdy     out  queue can accept (count != 2 and not in reset)
//   enq_msg     in   packed message: {type[2:0], opaque[o-1:0], len[l-1:0]}
//   enq_domain  in   security domain of the enqueued message
//   deq_val     out  head entry valid (count != 0)
//   deq_rdy     in   consumer accepts head
//   deq_type    out  unpacked type of head (0 when deq_val = 0)
//   deq_opaque  out  unpacked opaque of head (0 when deq_val = 0)
//   deq_len     out  unpacked len of head (0 when deq_val = 0)
//   deq_domain  out  stored domain of head (0 when deq_val = 0)
//   count       out  number of occupied entries, 0..2
// -----------------------------------------------------------------------------
module plab5_mcore_mem_resp_cmsg_unpack_queue #(
  parameter  int p_opaque_nbits = 8,
  parameter  int p_data_nbits   = 32,
  localparam int c_len_nbits    = $clog2(p_data_nbits / 8),
  localparam int c_msg_nbits    = 3 + p_opaque_nbits + c_len_nbits
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      enq_val,
  output logic                      enq_rdy,
  input  logic [c_msg_nbits-1:0]    enq_msg,
  input  logic                      enq_domain,

  output logic                      deq_val,
  input  logic                      deq_rdy,
  output logic [2:0]                deq_type,
  output logic [p_opaque_nbits-1:0] deq_opaque,
  output logic [c_len_nbits-1:0]    deq_len,
  output logic                      deq_domain,

  output logic [1:0]                count
);

  // Bit positions of the packed fields inside a message.
  localparam int c_opaque_lsb = c_len_nbits;
  localparam int c_type_lsb   = c_len_nbits + p_opaque_nbits;

  // Entry storage and pointers. Each pointer is one bit because the queue
  // depth is 2, so toggling a pointer advances it modulo 2.
  logic [c_msg_nbits-1:0] msg_q [2];
  logic                   dom_q [2];
  logic                   head_q;
  logic                   tail_q;
  logic [1:0]             count_q;

  logic                   enq_fire;
  logic                   deq_fire;
  logic [c_msg_nbits-1:0] head_msg;

  assign enq_rdy  = (count_q != 2'd2) && !reset;
  assign deq_val  = (count_q != 2'd0);
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;
  assign count    = count_q;

  // Control state: pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (enq_fire) tail_q <= ~tail_q;
      if (deq_fire) head_q <= ~head_q;
      // Enqueue and dequeue in the same cycle cancel out. Enqueue is refused
      // when the queue is full, and dequeue needs deq_val, so count stays in
      // the range 0..2.
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage.
  // NOTE: payload registers have no reset. Clearing the pointers and count
  // already makes every entry invalid, and the outputs are masked while the
  // queue is empty.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      msg_q[tail_q] <= enq_msg;
      dom_q[tail_q] <= enq_domain;
    end
  end

  // Unpack the head entry. All fields read zero while the queue is empty, so
  // stale or never-written contents are never exposed.
  // NOTE: every output gets a default at the top of the block, so no branch
  // can leave one unassigned and infer a latch.
  always_comb begin
    head_msg   = '0;
    deq_type   = '0;
    deq_opaque = '0;
    deq_len    = '0;
    deq_domain = 1'b0;
    if (deq_val) begin
      head_msg   = msg_q[head_q];
      deq_type   = head_msg[c_msg_nbits-1:c_type_lsb];
      deq_opaque = head_msg[c_type_lsb-1:c_opaque_lsb];
      deq_len    = head_msg[c_len_nbits-1:0];
      deq_domain = dom_q[head_q];
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_resp_cmsg_unpack_queue.sv
// -----------------------------------------------------------------------------
// Testbench for plab5_mcore_mem_resp_cmsg_unpack_queue at its default
// parameters (opaque 8 bits, len 2 bits, message 13 bits).
//
// The reference model is a plain queue of {message, domain} entries. Fields
// are unpacked from the stored message with shifts and masks. Inputs change
// just after a rising edge. Outputs are compared on the falling edge. The
// model advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_plab5_mcore_mem_resp_cmsg_unpack_queue;

  localparam int O = 8;
  localparam int L = 2;
  localparam int C = 3 + O + L;

  logic         clk;
  logic         reset;
  logic         enq_val;
  logic         enq_rdy;
  logic [C-1:0] enq_msg;
  logic         enq_domain;
  logic         deq_val;
  logic         deq_rdy;
  logic [2:0]   deq_type;
  logic [O-1:0] deq_opaque;
  logic [L-1:0] deq_len;
  logic         deq_domain;
  logic [1:0]   count;

  plab5_mcore_mem_resp_cmsg_unpack_queue dut (
    .clk        (clk),
    .reset      (reset),
    .enq_val    (enq_val),
    .enq_rdy    (enq_rdy),
    .enq_msg    (enq_msg),
    .enq_domain (enq_domain),
    .deq_val    (deq_val),
    .deq_rdy    (deq_rdy),
    .deq_type   (deq_type),
    .deq_opaque (deq_opaque),
    .deq_len    (deq_len),
    .deq_domain (deq_domain),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0] msg;
    logic         dom;
  } entry_t;

  entry_t model_q[$];
  bit     model_known = 1'b0;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every output against the model. Call this mid-cycle, while the
  // current inputs are applied.
  task automatic check_outputs(input string tag);
    int exp_count;
    int exp_type, exp_opq, exp_len, exp_dom;
    exp_count = model_q.size();
    exp_type = 0; exp_opq = 0; exp_len = 0; exp_dom = 0;
    if (exp_count != 0) begin
      exp_type = int'(model_q[0].msg) / 1024;
      exp_opq  = (int'(model_q[0].msg) / 4) % 256;
      exp_len  = int'(model_q[0].msg) % 4;
      exp_dom  = int'(model_q[0].dom);
    end
    check({tag, ".enq_rdy"}, 32'(enq_rdy),
          32'((exp_count != 2) && !reset));
    check({tag, ".deq_val"},    32'(deq_val),    32'(exp_count != 0));
    check({tag, ".count"},      32'(count),      32'(exp_count));
    check({tag, ".deq_type"},   32'(deq_type),   32'(exp_type));
    check({tag, ".deq_opaque"}, 32'(deq_opaque), 32'(exp_opq));
    check({tag, ".deq_len"},    32'(deq_len),    32'(exp_len));
    check({tag, ".deq_domain"}, 32'(deq_domain), 32'(exp_dom));
  endtask

  // One clock cycle: apply the inputs, check mid-cycle, then advance the model
  // at the rising edge. The enqueue decision uses the occupancy from before
  // the edge, so a full queue refuses a new entry even while it dequeues.
  task automatic step(input string tag, input logic ev, input logic [C-1:0] msg,
                      input logic dom, input logic dr, input logic rst);
    bit enq_ok, deq_ok;
    enq_val    = ev;
    enq_msg    = msg;
    enq_domain = dom;
    deq_rdy    = dr;
    reset      = rst;
    @(negedge clk);
    if (model_known) check_outputs(tag);
    enq_ok = ev && (model_q.size() != 2) && !rst;
    deq_ok = dr && (model_q.size() != 0);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_known = 1'b1;
    end else begin
      if (deq_ok) void'(model_q.pop_front());
      if (enq_ok) model_q.push_back('{msg: msg, dom: dom});
    end
    #1;
  endtask

  initial begin
    logic [C-1:0] rmsg;
    logic         rdom;
    enq_val = 1'b0; enq_msg = '0; enq_domain = 1'b0;
    deq_rdy = 1'b0; reset = 1'b1;

    // Reset.
    step("rst0", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step("rst1", 1'b1, 13'h123, 1'b1, 1'b1, 1'b1);

    // Empty queue with a willing consumer.
    for (int i = 0; i < 4; i++) step("empty", 1'b0, 13'h1ABC, 1'b1, 1'b1, 1'b0);

    // Single message.
    step("single_enq", 1'b1, 13'h0696, 1'b1, 1'b0, 1'b0);
    step("single_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("single.type_const",   32'(deq_type),   32'd1);
    check("single.opaque_const", 32'(deq_opaque), 32'hA5);
    check("single.len_const",    32'(deq_len),    32'd2);
    step("single_deq", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Fill the queue. The third enqueue attempt must be dropped.
    step("fill0", 1'b1, 13'h00F0, 1'b0, 1'b0, 1'b0);
    step("fill1", 1'b1, 13'h1FFF, 1'b1, 1'b0, 1'b0);
    step("fill_drop", 1'b1, 13'h0555, 1'b1, 1'b0, 1'b0);
    step("fill_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Queue full, enqueue and dequeue together: only the dequeue happens.
    step("full_both", 1'b1, 13'h0AAA, 1'b0, 1'b1, 1'b0);
    step("after_full_both", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("full_both.count_const", 32'(count),    32'd1);
    check("full_both.type_const",  32'(deq_type), 32'd7);

    // Pass-through at count 1: enqueue and dequeue together every cycle.
    for (int i = 0; i < 8; i++) begin
      rmsg = C'($urandom);
      rdom = 1'($urandom);
      step("pass", 1'b1, rmsg, rdom, 1'b1, 1'b0);
    end

    // Reset mid-operation with a full queue and an enqueue pending.
    step("refill", 1'b1, 13'h0123, 1'b0, 1'b0, 1'b0);
    step("mid_rst", 1'b1, 13'h1111, 1'b1, 1'b0, 1'b1);
    step("post_rst", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      rmsg = C'($urandom);
      rdom = 1'($urandom);
      step("rand", 1'($urandom), rmsg, rdom, 1'($urandom),
           ($urandom_range(0, 39) == 0));
    end

    // Drain, then confirm the queue reads empty.
    step("drain0", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("drain1", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("drained", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
